banked_ram: RTL

- Parametrised successor to the single-width three-bank byte RAM: NUM_BANKS banks of BANK_DEPTH x DATA_W block RAM behind one flat address space.
- Single clock, synchronous read with registered bank select, out-of-range detection and a power-on zero-fill state machine.
- Serves as the CPU data/instruction scratch memory on the ICE40 target; one read port and one write port, both usable every cycle.

---
 rtl/ram_pkg.sv | 24 ++
 rtl/ram_bank.sv | 28 ++
 rtl/banked_ram.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for the banked scratch RAM: FSM state encoding,
// default geometry and a constant clog2 usable in parameter expressions.
package ram_pkg;

   typedef enum logic {INIT, RUN} state_t;

   localparam int DEF_DATA_W     = 8;
   localparam int DEF_BANK_DEPTH = 512;
   localparam int DEF_NUM_BANKS  = 3;

   // Returns at least 1 so that derived port widths never collapse to zero.
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result++;
         v = v >> 1;
      end
      return (result < 1) ? 1 : result;
   endfunction

endpackage

// File: rtl/ram_bank.sv
// One DEPTH x DATA_W simple dual-port RAM with registered read, written so
// that it maps onto a single ICE40 block RAM.
module ram_bank #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 512,
   parameter int AW     = 9
) (
   input  logic              CLK_c,
   input  logic              re,
   input  logic              we,
   input  logic [AW-1:0]     raddr,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // NOTE: the array has no reset branch; a reset on block RAM contents prevents
   // BRAM inference, so clearing is done by the top-level zero-fill sequence.
   // NOTE: non-blocking assignments keep the read returning the pre-write word
   // when both ports hit the same location on one edge.
   always_ff @(posedge CLK_c) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/banked_ram.sv
// NUM_BANKS x BANK_DEPTH word RAM behind one flat address space, with zero-fill
// after reset. Define BANKED_RAM_BYPASS_EN for write-first same-address reads.
module banked_ram
   import ram_pkg::*;
#(
   parameter  int DATA_W     = DEF_DATA_W,
   parameter  int BANK_DEPTH = DEF_BANK_DEPTH,
   parameter  int NUM_BANKS  = DEF_NUM_BANKS,
   localparam int BANK_AW    = clog2(BANK_DEPTH),
   localparam int ADDR_W     = clog2(NUM_BANKS * BANK_DEPTH)
) (
   input  logic              CLK_c,
   input  logic              RESET_c,
   output logic              READY,
   input  logic              RD_REQ_c,
   input  logic [ADDR_W-1:0] RADDR_c,
   output logic              RD_VALID,
   output logic [DATA_W-1:0] RDATA_OUT,
   output logic              RD_ERR,
   input  logic              WR_REQ_c,
   input  logic [ADDR_W-1:0] WADDR_c,
   input  logic [DATA_W-1:0] WDATA_IN,
   output logic              WR_ERR
);

   localparam int BANK_W = (ADDR_W > BANK_AW) ? ADDR_W - BANK_AW : 1;
   localparam logic [ADDR_W:0] NUM_WORDS = (ADDR_W + 1)'(NUM_BANKS * BANK_DEPTH);

   state_t               state, state_nxt;
   logic [BANK_AW-1:0]   init_cnt;
   logic                 rd_acc, wr_acc, rd_in_range, wr_in_range;
   logic [BANK_W-1:0]    rd_bank, wr_bank, rd_bank_q;
   logic                 rd_oor_q;
   logic [NUM_BANKS-1:0] bank_re, bank_we;
   logic [BANK_AW-1:0]   bank_waddr;
   logic [DATA_W-1:0]    bank_wdata, bank_mux, rd_word, rdata_hold;
   logic [DATA_W-1:0]    bank_rdata [NUM_BANKS];

   assign READY       = (state == RUN);
   assign rd_acc      = RD_REQ_c & READY;
   assign wr_acc      = WR_REQ_c & READY;
   assign rd_bank     = BANK_W'(RADDR_c >> BANK_AW);
   assign wr_bank     = BANK_W'(WADDR_c >> BANK_AW);
   assign rd_in_range = ({1'b0, RADDR_c} < NUM_WORDS);
   assign wr_in_range = ({1'b0, WADDR_c} < NUM_WORDS);

   always_ff @(posedge CLK_c) begin
      if (RESET_c) begin
         state    <= INIT;
         init_cnt <= '0;
      end else begin
         state    <= state_nxt;
         init_cnt <= (state == INIT) ? init_cnt + 1'b1 : '0;
      end
   end

   always_comb begin
      state_nxt = state;
      if (state == INIT && init_cnt == BANK_AW'(BANK_DEPTH - 1)) state_nxt = RUN;
   end

   // During zero-fill every bank is written at the same offset in parallel.
   always_comb begin
      bank_re    = '0;
      bank_we    = '0;
      bank_waddr = (state == INIT) ? init_cnt : WADDR_c[BANK_AW-1:0];
      bank_wdata = (state == INIT) ? '0 : WDATA_IN;
      for (int b = 0; b < NUM_BANKS; b++) begin
         bank_re[b] = rd_acc && rd_in_range && (rd_bank == BANK_W'(b));
         bank_we[b] = (state == INIT) || (wr_acc && wr_in_range && (wr_bank == BANK_W'(b)));
      end
   end

   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      ram_bank #(.DATA_W(DATA_W), .DEPTH(BANK_DEPTH), .AW(BANK_AW)) u_bank (
         .CLK_c (CLK_c),
         .re    (bank_re[g]),
         .we    (bank_we[g]),
         .raddr (RADDR_c[BANK_AW-1:0]),
         .waddr (bank_waddr),
         .wdata (bank_wdata),
         .rdata (bank_rdata[g])
      );
   end

`ifdef BANKED_RAM_BYPASS_EN
   logic              byp_hit_q;
   logic [DATA_W-1:0] byp_data_q;

   always_ff @(posedge CLK_c) begin
      if (RESET_c) begin
         byp_hit_q  <= 1'b0;
         byp_data_q <= '0;
      end else begin
         byp_hit_q  <= rd_acc && wr_acc && rd_in_range && wr_in_range && (RADDR_c == WADDR_c);
         byp_data_q <= WDATA_IN;
      end
   end
`endif

   always_ff @(posedge CLK_c) begin
      if (RESET_c) begin
         RD_VALID   <= 1'b0;
         RD_ERR     <= 1'b0;
         WR_ERR     <= 1'b0;
         rd_bank_q  <= '0;
         rd_oor_q   <= 1'b0;
         rdata_hold <= '0;
      end else begin
         RD_VALID   <= rd_acc;
         RD_ERR     <= rd_acc & ~rd_in_range;
         WR_ERR     <= wr_acc & ~wr_in_range;
         rdata_hold <= RDATA_OUT;
         if (rd_acc) begin
            rd_bank_q <= rd_bank;
            rd_oor_q  <= ~rd_in_range;
         end
      end
   end

   // NOTE: every variable gets a default at the top of the block, so no path
   // through the loop or the optional bypass can leave one unassigned (no latch).
   always_comb begin
      bank_mux = '0;
      for (int b = 0; b < NUM_BANKS; b++)
         if (rd_bank_q == BANK_W'(b)) bank_mux = bank_rdata[b];
      rd_word = rd_oor_q ? '0 : bank_mux;
`ifdef BANKED_RAM_BYPASS_EN
      if (byp_hit_q) rd_word = byp_data_q;
`endif
      RDATA_OUT = RD_VALID ? rd_word : rdata_hold;
   end

endmodule
